// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
// Instruction-fetch front end between the PC and the decode pipeline register.
// It issues word fetches to a pipelined, in-order instruction memory, buffers
// the returned words with their PC and PC+4 in a small FIFO, and hands them to
// decode. A redirect from execute flushes the FIFO and drops every response
// that is still in flight.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   mem_req_valid/ready/addr   fetch request channel (word-aligned address)
//   mem_rsp_valid/data         in-order response channel, variable latency
//   instr_valid/ready          FIFO head handshake towards decode
//   instr, instr_pc, instr_pc_plus4   head entry contents
//   redirect, redirect_pc      taken branch / jump target from execute
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer raises valid independent of ready. On the request
// channel valid only falls without a transfer when credits run out or a
// redirect is present; the address is held stable while valid waits for ready.
// The response channel has no ready: a credit scheme (buffered entries plus
// requests in flight never exceed DEPTH) guarantees every response a slot.
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [31:0]   fetchPc;
  logic [31:0]   respPc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] dropCnt;
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;

  logic [31:0] fifoInstr [DEPTH];
  logic [31:0] fifoPc    [DEPTH];
  logic [31:0] fifoPc4   [DEPTH];

  logic [CW:0]   inUse;
  logic          creditOk;
  logic          reqFire;
  logic          rspTake;
  logic          rspPush;
  logic          popFire;
  logic [31:0]   target;

  // Slots already committed: buffered entries plus requests still in flight.
  assign inUse    = {1'b0, count} + {1'b0, outstanding};
  assign creditOk = inUse < (CW+1)'(DEPTH);

  assign mem_req_valid = ~reset & ~redirect & creditOk;
  assign mem_req_addr  = fetchPc;
  assign reqFire       = mem_req_valid & mem_req_ready;

  // A response with nothing outstanding is a leftover from before a reset.
  assign rspTake = mem_rsp_valid & (outstanding != '0);
  assign rspPush = rspTake & (dropCnt == '0) & ~redirect;

  assign instr_valid    = count != '0;
  assign instr          = fifoInstr[headPtr];
  assign instr_pc       = fifoPc[headPtr];
  assign instr_pc_plus4 = fifoPc4[headPtr];
  assign popFire        = instr_valid & instr_ready & ~redirect;

  // Low two bits of the target are forced to zero (word alignment).
  assign target = redirect_pc & ~32'h3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      dropCnt     <= '0;
      headPtr     <= '0;
      tailPtr     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifoInstr[i] <= '0;
        fifoPc[i]    <= '0;
        fifoPc4[i]   <= '0;
      end
    end else begin
      // Net of issue and response; reqFire is already low during a redirect.
      outstanding <= outstanding + CW'(reqFire) - CW'(rspTake);

      if (redirect) begin
        count   <= '0;
        headPtr <= '0;
        tailPtr <= '0;
        fetchPc <= target;
        respPc  <= target;
        // Everything still in flight after this edge belongs to the old path.
        dropCnt <= outstanding - CW'(rspTake);
      end else begin
        if (reqFire) begin
          fetchPc <= fetchPc + 32'd4;
        end
        if (rspTake && (dropCnt != '0)) begin
          dropCnt <= dropCnt - CW'(1);
        end
        if (rspPush) begin
          fifoInstr[tailPtr] <= mem_rsp_data;
          fifoPc[tailPtr]    <= respPc;
          fifoPc4[tailPtr]   <= respPc + 32'd4;
          tailPtr            <= tailPtr + PW'(1);
          respPc             <= respPc + 32'd4;
        end
        if (popFire) begin
          headPtr <= headPtr + PW'(1);
        end
        count <= count + CW'(rspPush) - CW'(popFire);
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (inUse <= (CW+1)'(DEPTH))
        else $error("credit invariant broken: count+outstanding > DEPTH");
      assert (dropCnt <= outstanding)
        else $error("drop count exceeds outstanding requests");
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  // ---------------- memory and reference model ----------------
  typedef struct { logic [31:0] addr; int due; } mem_t;
  typedef struct { logic [31:0] addr; bit drop; } req_t;

  mem_t        memQ[$];   // requests the memory still has to answer
  req_t        mReq[$];   // requests in flight, with old-path marking
  logic [31:0] exp_q[$];  // PCs that decode must see, in order
  logic [31:0] mFetchPc;

  int cyc;
  int nChecks;
  int nPass;
  int rdyPct, irPct, redirPermille, latMin, latMax;
  bit forceRedir;
  logic [31:0] forcePc;
  bit releaseReset;
  bit injectStale;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pickTarget();
    if ($urandom_range(3) == 0) return 32'hFFFF_FFE0 + $urandom_range(31);
    return $urandom();
  endfunction

  function automatic logic [31:0] headOr();
    return (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic doReset();
    @(negedge clk);
    reset         = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_req_ready = 1'b0;
    instr_ready   = 1'b0;
    mReq.delete();
    exp_q.delete();
    memQ.delete();
    mFetchPc = RESET_PC;
    cyc      = 0;
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_addr", mem_req_addr, RESET_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_instr_pc4", instr_pc_plus4, 32'd0);
    releaseReset = 1'b1;
  endtask

  // One clock cycle: drive at negedge, compare, then advance the model at posedge.
  task automatic step();
    bit   expValid;
    bit   hs;
    req_t r;
    @(negedge clk);
    cyc++;
    if (releaseReset) begin
      reset        = 1'b0;
      releaseReset = 1'b0;
    end
    mem_req_ready = ($urandom_range(99) < rdyPct);
    instr_ready   = ($urandom_range(99) < irPct);
    redirect      = forceRedir || ($urandom_range(999) < redirPermille);
    redirect_pc   = forceRedir ? forcePc : pickTarget();
    forceRedir    = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = $urandom();
    if (injectStale) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
      injectStale   = 1'b0;
    end else if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = memfn(memQ[0].addr);
      void'(memQ.pop_front());
    end
    #1;
    // scoreboard compare
    expValid = !redirect && (exp_q.size() + mReq.size() < DEPTH);
    chk("mem_req_valid", 32'(mem_req_valid), 32'(expValid));
    chk("mem_req_addr", mem_req_addr, mFetchPc);
    chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() > 0) begin
      chk("instr_pc", instr_pc, exp_q[0]);
      chk("instr_pc_plus4", instr_pc_plus4, exp_q[0] + 32'd4);
      chk("instr", instr, memfn(exp_q[0]));
    end
    @(posedge clk);
    hs = expValid && mem_req_ready;
    if (redirect) begin
      if (mem_rsp_valid && mReq.size() > 0) void'(mReq.pop_front());
      exp_q.delete();
      for (int i = 0; i < mReq.size(); i++) mReq[i].drop = 1'b1;
      mFetchPc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (exp_q.size() > 0 && instr_ready) void'(exp_q.pop_front());
      if (mem_rsp_valid && mReq.size() > 0) begin
        r = mReq.pop_front();
        if (!r.drop) exp_q.push_back(r.addr);
      end
      if (hs) begin
        mReq.push_back('{addr: mFetchPc, drop: 1'b0});
        memQ.push_back('{addr: mFetchPc, due: cyc + int'($urandom_range(latMax, latMin))});
        mFetchPc = mFetchPc + 32'd4;
      end
    end
  endtask

  task automatic setMode(input int rdy, input int ir, input int redir, input int lmin, input int lmax);
    rdyPct = rdy; irPct = ir; redirPermille = redir; latMin = lmin; latMax = lmax;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nChecks = 0; nPass = 0;
    forceRedir = 1'b0; forcePc = '0; releaseReset = 1'b0; injectStale = 1'b0;
    reset = 1'b1;
    mem_req_ready = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    setMode(100, 100, 0, 1, 1);
    repeat (3) @(negedge clk);

    // Streaming with single-cycle memory.
    doReset();
    setMode(100, 100, 0, 1, 1);
    step(); step();
    chk("s1_model_head", headOr(), 32'h0);
    #1;
    chk("s1_valid", 32'(instr_valid), 32'd1);
    chk("s1_pc0", instr_pc, 32'h0);
    chk("s1_pc0_plus4", instr_pc_plus4, 32'h4);
    step();
    #1;
    chk("s1_pc1", instr_pc, 32'h4);
    chk("s1_pc1_plus4", instr_pc_plus4, 32'h8);
    chk("s1_next_addr", mem_req_addr, 32'hC);
    repeat (20) step();

    // Decode stalled: credits fill the FIFO, then one pop frees one credit.
    doReset();
    setMode(100, 0, 0, 1, 1);
    repeat (8) step();
    chk("s2_model_count", 32'(exp_q.size()), 32'd4);
    chk("s2_model_tail", (exp_q.size() == 4) ? exp_q[3] : 32'hFFFF_FFFF, 32'hC);
    #1;
    chk("s2_req_stopped", 32'(mem_req_valid), 32'd0);
    chk("s2_head_pc", instr_pc, 32'h0);
    irPct = 100;
    step();
    #1;
    chk("s2_resume_valid", 32'(mem_req_valid), 32'd1);
    chk("s2_resume_addr", mem_req_addr, 32'h10);

    // Redirect with three requests in flight, one of them answering that cycle.
    doReset();
    setMode(100, 100, 0, 3, 3);
    for (int i = 0; i < 20 && mReq.size() < 3; i++) step();
    chk("s3_inflight", 32'(mReq.size()), 32'd3);
    forceRedir = 1'b1; forcePc = 32'h43;
    step();
    #1;
    chk("s3_flushed", 32'(instr_valid), 32'd0);
    chk("s3_target_addr", mem_req_addr, 32'h40);
    for (int i = 0; i < 30 && exp_q.size() == 0; i++) step();
    chk("s3_first_pc", headOr(), 32'h40);
    repeat (10) step();

    // Request channel stalled, then wrap-around past the top of memory.
    setMode(0, 100, 0, 1, 2);
    repeat (5) step();
    setMode(100, 100, 0, 1, 2);
    forceRedir = 1'b1; forcePc = 32'hFFFF_FFF4;
    repeat (30) step();

    // Reset while holding two entries with a response pending.
    doReset();
    setMode(100, 0, 0, 2, 2);
    for (int i = 0; i < 20 && !(exp_q.size() == 2 && mReq.size() >= 1); i++) step();
    chk("s6_precond", 32'(exp_q.size() == 2 && mReq.size() >= 1), 32'd1);
    doReset();
    setMode(100, 100, 0, 2, 2);
    injectStale = 1'b1;
    repeat (12) step();

    // Randomized phases.
    for (int p = 0; p < 15; p++) begin
      setMode($urandom_range(100), $urandom_range(100, 20), $urandom_range(60),
              1, $urandom_range(5, 1));
      repeat (200) step();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
